// File: rtl/fifo_pkg.sv
// Shared constants and helper functions for the parameterised synchronous FIFO.
//   FIFO_DEF_WIDTH / FIFO_DEF_DEPTH : default word width and entry count
//   FIFO_DEF_AE_LEVEL               : default almost_empty threshold
//   FIFO_AF_MARGIN                  : default almost_full distance below DEPTH
//   count_width(depth)              : bits needed to hold 0..depth
//   is_pow2(v)                      : true when v is a non-zero power of two
package fifo_pkg;

  localparam int unsigned FIFO_DEF_WIDTH    = 8;
  localparam int unsigned FIFO_DEF_DEPTH    = 32;
  localparam int unsigned FIFO_DEF_AE_LEVEL = 4;
  localparam int unsigned FIFO_AF_MARGIN    = 4;

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
// The array itself is never reset; only the pointers around it are.
//   clk_i      : clock
//   wr_en_i    : write strobe (already qualified by the controller)
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_addr_i  : read address
//   rd_data_o  : combinational read data
module fifo_mem import fifo_pkg::*; #(
  parameter int unsigned WIDTH = FIFO_DEF_WIDTH,
  parameter int unsigned DEPTH = FIFO_DEF_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with threshold flags and sticky error flags.
//   clk                        : clock, all state on rising edge
//   rst                        : asynchronous active-low reset
//   flush                      : synchronous clear of pointers, count, errors, data_out
//   wren / rden                : write / read requests
//   data_in / data_out         : write data / read data (registered or fall-through)
//   full / empty               : DEPTH / zero entries held
//   almost_full / almost_empty : count >= AF_LEVEL / count <= AE_LEVEL
//   count                      : entries held
//   overflow / underflow       : sticky rejected-write / rejected-read flags
module sync_fifo_param import fifo_pkg::*; #(
  parameter int unsigned WIDTH    = FIFO_DEF_WIDTH,
  parameter int unsigned DEPTH    = FIFO_DEF_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - FIFO_AF_MARGIN,
  parameter int unsigned AE_LEVEL = FIFO_DEF_AE_LEVEL,
  parameter int unsigned FWFT     = 0,
  localparam int unsigned CW      = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wren,
  input  logic             rden,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two and at least 4");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
    $error("sync_fifo_param: AE_LEVEL must be below AF_LEVEL");
  end

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [CW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] rd_data;

  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // A write is refused when full even if a read frees a slot this same cycle.
  assign wr_acc = wren & ~full  & ~flush;
  assign rd_acc = rden & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + CW'(1);
      if (rd_acc) rd_ptr_d = rd_ptr_q + CW'(1);
      if (wren && full)  ovf_d = 1'b1;
      if (rden && empty) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk_i     (clk),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q[AW-1:0]),
    .wr_data_i (data_in),
    .rd_addr_i (rd_ptr_q[AW-1:0]),
    .rd_data_o (rd_data)
  );

  if (FWFT != 0) begin : g_fwft
    // Head entry is shown directly; forced to zero while empty so reset
    // and flush both present a clean zero.
    assign data_out = empty ? '0 : rd_data;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q, dout_d;

    always_comb begin
      dout_d = dout_q;
      if (flush)       dout_d = '0;
      else if (rd_acc) dout_d = rd_data;
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) dout_q <= '0;
      else      dout_q <= dout_d;
    end

    assign data_out = dout_q;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: a registered-read instance and a fall-through instance
// share all stimulus and are compared each cycle against a queue-based model.
module tb_sync_fifo_param;

  localparam int W  = 8;
  localparam int D  = 32;
  localparam int CW = 6;
  localparam int AF = D - 4;
  localparam int AE = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0, wren = 1'b0, rden = 1'b0;
  logic [W-1:0]  data_in = '0;

  logic [W-1:0]  dout0, dout1;
  logic          full0, empty0, af0, ae0, ovf0, unf0;
  logic          full1, empty1, af1, ae1, ovf1, unf1;
  logic [CW-1:0] cnt0, cnt1;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] q[$];
  bit           m_ovf, m_unf;
  logic [W-1:0] m_dout0;

  always #5 clk = ~clk;

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .flush(flush), .wren(wren), .rden(rden),
    .data_in(data_in), .data_out(dout0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0),
    .overflow(ovf0), .underflow(unf0)
  );

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .wren(wren), .rden(rden),
    .data_in(data_in), .data_out(dout1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1),
    .overflow(ovf1), .underflow(unf1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_dout0 = '0;
  endfunction

  // One clock of FIFO behaviour from the rules: flush wins, a write needs room
  // before this cycle, a read needs data before this cycle.
  function automatic void model_clock(input logic w, input logic r, input logic f,
                                      input logic [W-1:0] d);
    int  sz;
    bit  wa, ra;
    sz = q.size();
    if (f) begin
      model_reset();
    end else begin
      wa = w && (sz < D);
      ra = r && (sz > 0);
      if (w && !wa) m_ovf = 1'b1;
      if (r && !ra) m_unf = 1'b1;
      if (ra) m_dout0 = q.pop_front();
      if (wa) q.push_back(d);
    end
  endfunction

  task automatic compare_all();
    int sz;
    sz = q.size();
    check_eq("count_std",  32'(cnt0),  32'(sz));
    check_eq("count_fwft", 32'(cnt1),  32'(sz));
    check_eq("full_std",   32'(full0), 32'(sz == D));
    check_eq("full_fwft",  32'(full1), 32'(sz == D));
    check_eq("empty_std",  32'(empty0), 32'(sz == 0));
    check_eq("empty_fwft", 32'(empty1), 32'(sz == 0));
    check_eq("afull_std",  32'(af0),   32'(sz >= AF));
    check_eq("afull_fwft", 32'(af1),   32'(sz >= AF));
    check_eq("aempty_std", 32'(ae0),   32'(sz <= AE));
    check_eq("aempty_fwft",32'(ae1),   32'(sz <= AE));
    check_eq("ovf_std",    32'(ovf0),  32'(m_ovf));
    check_eq("ovf_fwft",   32'(ovf1),  32'(m_ovf));
    check_eq("unf_std",    32'(unf0),  32'(m_unf));
    check_eq("unf_fwft",   32'(unf1),  32'(m_unf));
    check_eq("dout_std",   32'(dout0), 32'(m_dout0));
    if (sz > 0) check_eq("dout_fwft_head", 32'(dout1), 32'(q[0]));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_cnt0"},  32'(cnt0),   0);
    check_eq({tag, "_cnt1"},  32'(cnt1),   0);
    check_eq({tag, "_empty"}, 32'({empty0, empty1, ae0, ae1}), 32'hF);
    check_eq({tag, "_full"},  32'({full0, full1, af0, af1}),   32'h0);
    check_eq({tag, "_err"},   32'({ovf0, ovf1, unf0, unf1}),   32'h0);
    check_eq({tag, "_dout0"}, 32'(dout0),  0);
    check_eq({tag, "_dout1"}, 32'(dout1),  0);
  endtask

  // Inputs are applied just after a falling edge, outputs sampled at the next one.
  task automatic cyc(input logic w, input logic r, input logic f, input logic [W-1:0] d);
    wren = w; rden = r; flush = f; data_in = d;
    @(posedge clk);
    model_clock(w, r, f, d);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    logic [W-1:0] d;
    int wp, rp;

    // Reset state
    model_reset();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b1;

    // Fill with 0x01..0x20 then drain in order
    for (int i = 1; i <= D; i++) cyc(1'b1, 1'b0, 1'b0, W'(i));
    check_eq("burst_full_after_32", 32'(full0), 1);
    for (int i = 1; i <= D; i++) begin
      cyc(1'b0, 1'b1, 1'b0, '0);
      check_eq("burst_read_order", 32'(dout0), 32'(i));
    end
    check_eq("burst_empty_after_32", 32'(empty0), 1);

    // Full FIFO with simultaneous write and read: read taken, write refused
    for (int i = 0; i < D; i++) cyc(1'b1, 1'b0, 1'b0, W'($urandom));
    cyc(1'b1, 1'b1, 1'b0, 8'h77);
    check_eq("full_wr_rd_count", 32'(cnt0), 31);
    check_eq("full_wr_rd_ovf",   32'(ovf0), 1);

    // Empty FIFO read sets underflow; flush clears it
    cyc(1'b0, 1'b0, 1'b1, '0);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check_eq("empty_rd_unf",   32'(unf0), 1);
    check_eq("empty_rd_count", 32'(cnt0), 0);
    cyc(1'b0, 1'b0, 1'b1, '0);
    check_eq("flush_clears_unf", 32'(unf0), 0);

    // Steady simultaneous traffic at count 10, pointers wrap several times
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, W'($urandom));
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b1, 1'b0, W'($urandom));
    check_eq("steady_count10", 32'(cnt0), 10);

    // Fall-through: word visible one cycle after its write, pop empties it
    cyc(1'b0, 1'b0, 1'b1, '0);
    cyc(1'b1, 1'b0, 1'b0, 8'hA5);
    check_eq("fwft_a5_visible", 32'(dout1), 32'hA5);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check_eq("fwft_pop_empty", 32'(empty1), 1);

    // Asynchronous reset in the middle of a burst at count 17
    for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0, 1'b0, W'($urandom));
    check_eq("pre_reset_count17", 32'(cnt0), 17);
    wren = 1'b1; rden = 1'b1; data_in = 8'h3C;
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_values("async_reset");
    model_reset();
    @(posedge clk);
    #1 check_reset_values("held_reset");
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 8'h5A);
    check_eq("first_write_after_reset", 32'(cnt0), 1);
    cyc(1'b0, 1'b1, 1'b0, '0);
    check_eq("first_read_after_reset", 32'(dout0), 32'h5A);

    // Randomised traffic with shifting write/read bias to visit full and empty
    for (int blk = 0; blk < 40; blk++) begin
      wp = $urandom_range(10, 90);
      rp = $urandom_range(10, 90);
      for (int i = 0; i < 50; i++) begin
        d = W'($urandom);
        cyc(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < rp),
            ($urandom_range(0, 199) == 0), d);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 32, number of entries; power of two, >=4.
REQ-003 Parameter AF_LEVEL, default DEPTH-4, almost_full asserts when count >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, default 4, almost_empty asserts when count <= AE_LEVEL.
REQ-005 Parameter FWFT, default 0, 0 = registered read (standard), 1 = first-word fall-through.
REQ-006 Port clk  input  1  single clock; all state on rising edge.
REQ-007 Port rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-008 Port flush  input  1  synchronous clear of contents, pointers, count and error flags.
REQ-009 Port wren  input  1  write request.
REQ-010 Port rden  input  1  read request.
REQ-011 Port data_in  input  WIDTH  write data.
REQ-012 Port data_out  output  WIDTH  read data.
REQ-013 Port full / empty  output  1 each  DEPTH entries / zero entries held.
REQ-014 Port almost_full / almost_empty  output  1 each  threshold flags per REQ-003/004.
REQ-015 Port count  output  $clog2(DEPTH)+1  entries currently held.
REQ-016 Port overflow / underflow  output  1 each  sticky error flags.

Function
REQ-017 Write accepted iff wren=1, full=0 and flush=0; data_in stored at write pointer, pointer +1.
REQ-018 Read accepted iff rden=1, empty=0 and flush=0; read pointer +1.
REQ-019 Pointers carry one extra MSB; wrap modulo 2*DEPTH; count = wrptr - rdptr, width per REQ-015.
REQ-020 full, empty, almost_full, almost_empty and count derive from registered pointers only, updated the cycle after an accepted access.
REQ-021 Write while full rejected even with rden=1 in the same cycle; read while empty rejected even with wren=1.
REQ-022 Write and read accepted in the same cycle: count unchanged, both pointers advance.
REQ-023 FWFT=0: data_out loads mem[rdptr] on the edge that accepts the read (valid the cycle after rden); holds value otherwise.
REQ-024 FWFT=1: data_out presents the head entry whenever empty=0; an accepted read advances to the next entry on the following cycle; data_out is don't-care while empty.
REQ-025 Written word readable no earlier than the cycle after its write edge (no same-cycle write-to-read bypass).
REQ-026 overflow sets on rejected write due to full; underflow sets on rejected read due to empty; both hold until flush or reset.
REQ-027 flush has priority over wren and rden: pointers and count to 0, error flags to 0, data_out to 0; memory contents not cleared.

Reset
REQ-028 While rst=0: pointers 0, count 0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, data_out=0.
REQ-029 Reset asserted mid-operation aborts in-flight accesses immediately; memory array is not reset.
REQ-030 First access accepted on the first rising edge after rst deasserts.

Structure
REQ-031 Storage lives in sub-module fifo_mem (WIDTH x DEPTH, one synchronous write port, one asynchronous read port).
REQ-032 Shared package fifo_pkg holds default WIDTH/DEPTH/threshold constants and a count-width helper function.
REQ-033 Elaboration check fails if DEPTH is not a power of two or AE_LEVEL >= AF_LEVEL.

Verification
REQ-034 Reset, write 0x01..0x20 (DEPTH=32), then read 32 -> data 0x01..0x20 in order, full after 32nd write, empty after 32nd read.
REQ-035 Full FIFO, wren=1 rden=1 one cycle -> read accepted, write rejected, count 31, overflow=1.
REQ-036 Empty FIFO, rden=1 -> underflow=1, count 0; then flush -> underflow=0.
REQ-037 Continuous simultaneous wr/rd at count 10 for 100 cycles -> count stays 10, pointers wrap, data order intact.
REQ-038 FWFT=1, write 0xA5 -> data_out=0xA5 one cycle later with no rden; rden pops and empty=1 next cycle.
REQ-039 rst=0 asynchronously mid-burst at count 17 -> all outputs reach reset values before next clock edge.
